// File: rtl/sync_r2w_nstage.sv
// Write-side synchronizer for the async FIFO read pointer: an SYNC_STAGES-deep Gray
// capture chain, registered Gray->binary conversion, write-side fill level and Gray-step checker.
module sync_r2w_nstage #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit CHECK_GRAY  = 1'b1
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic [ADDRSIZE:0]   wbin,
    input  logic                err_clr,
    output logic [ADDRSIZE:0]   wq_rptr,
    output logic [ADDRSIZE:0]   wq_rptr_bin,
    output logic                rptr_upd,
    output logic [ADDRSIZE:0]   wfill,
    output logic                gray_err
);

    localparam int PW = ADDRSIZE + 1;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_depth
            $fatal(1, "sync_r2w_nstage: SYNC_STAGES must be 2..4");
        end
    endgenerate

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] prev;
    logic [PW-1:0] step;
    logic          multi_bit;

    // Plain flop chain: only stage 0 touches the asynchronous pointer.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // More than one bit set in the step means an illegal Gray transition.
    assign step      = wq_rptr ^ prev;
    assign multi_bit = (step & (step - PW'(1))) != '0;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            prev        <= '0;
            wq_rptr_bin <= '0;
            rptr_upd    <= 1'b0;
            wfill       <= '0;
        end else begin
            prev        <= wq_rptr;
            wq_rptr_bin <= gray2bin(wq_rptr);
            rptr_upd    <= (wq_rptr != prev);
            wfill       <= wbin - wq_rptr_bin;
        end
    end

    generate
        if (CHECK_GRAY) begin : g_check
            // A new error in the same cycle as err_clr keeps the flag set.
            always_ff @(posedge wclk) begin
                if (!wrst_n) begin
                    gray_err <= 1'b0;
                end else if (multi_bit) begin
                    gray_err <= 1'b1;
                end else if (err_clr) begin
                    gray_err <= 1'b0;
                end
            end
        end else begin : g_no_check
            assign gray_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_sync_r2w_nstage.sv
// Bench for sync_r2w_nstage: a depth-2 and a depth-4 instance share stimulus and are
// compared against a history-based reference model plus directed literal checks.
module tb_sync_r2w_nstage;

    logic       wclk;
    logic       wrst_n;
    logic [4:0] rptr;
    logic [4:0] wbin;
    logic       err_clr;

    logic [4:0] wq   [2];
    logic [4:0] wqb  [2];
    logic [4:0] wf   [2];
    logic       upd  [2];
    logic       gerr [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: rptr history (index 0 = value sampled on the latest edge).
    logic [4:0] r_hist [$];
    int         dep    [2] = '{2, 4};
    logic [4:0] exp_wq   [2];
    logic [4:0] exp_wqb  [2];
    logic [4:0] exp_wf   [2];
    logic       exp_upd  [2];
    logic       exp_gerr [2];

    sync_r2w_nstage #(.ADDRSIZE(4), .SYNC_STAGES(2), .CHECK_GRAY(1'b1)) dut2 (
        .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wbin(wbin), .err_clr(err_clr),
        .wq_rptr(wq[0]), .wq_rptr_bin(wqb[0]), .rptr_upd(upd[0]), .wfill(wf[0]),
        .gray_err(gerr[0])
    );

    sync_r2w_nstage #(.ADDRSIZE(4), .SYNC_STAGES(4), .CHECK_GRAY(1'b1)) dut4 (
        .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wbin(wbin), .err_clr(err_clr),
        .wq_rptr(wq[1]), .wq_rptr_bin(wqb[1]), .rptr_upd(upd[1]), .wfill(wf[1]),
        .gray_err(gerr[1])
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b = g;
        for (int k = 1; k < 5; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Apply one cycle of inputs, clock it, advance the model, settle past the edge.
    task automatic tick(input logic rst_v, input logic [4:0] r_v, input logic [4:0] wb_v,
                        input logic clr_v);
        int s;
        @(negedge wclk);
        wrst_n  = ~rst_v;
        rptr    = r_v;
        wbin    = wb_v;
        err_clr = clr_v;
        @(posedge wclk);
        if (rst_v) begin
            r_hist = {};
            repeat (8) r_hist.push_back(5'd0);
            for (int d = 0; d < 2; d++) begin
                exp_wq[d] = '0; exp_wqb[d] = '0; exp_wf[d] = '0;
                exp_upd[d] = 1'b0; exp_gerr[d] = 1'b0;
            end
        end else begin
            r_hist.push_front(r_v);
            void'(r_hist.pop_back());
            for (int d = 0; d < 2; d++) begin
                s = dep[d];
                exp_wq[d]  = r_hist[s-1];
                exp_wqb[d] = g2b(r_hist[s]);
                exp_upd[d] = (r_hist[s] != r_hist[s+1]);
                exp_wf[d]  = wb_v - g2b(r_hist[s+1]);
                if ($countones(r_hist[s] ^ r_hist[s+1]) > 1) exp_gerr[d] = 1'b1;
                else if (clr_v) exp_gerr[d] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 5'($urandom), 5'($urandom), 1'b0);
        tick(1'b1, 5'($urandom), 5'($urandom), 1'b1);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({wq[d], wqb[d], wf[d], upd[d], gerr[d]} !== 17'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got wq=%b wqb=%0d wf=%0d upd=%b err=%b expected all 0",
                         d, wq[d], wqb[d], wf[d], upd[d], gerr[d]);
            end
        end
    endtask

    // Single-step latency for depth 2 (edges 2/3/4) and depth 4 (edges 4/5/6).
    task automatic test_step_and_depth();
        tick(1'b1, 5'd0, 5'd3, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            tick(1'b0, 5'd1, 5'd3, 1'b0);
            n_checks++;
            if (wq[0] !== ((e >= 2) ? 5'd1 : 5'd0)) begin
                n_fail++; $display("FAIL step_wq e%0d: got %b expected %b", e, wq[0], (e >= 2) ? 5'd1 : 5'd0);
            end
            n_checks++;
            if (upd[0] !== (e == 3)) begin
                n_fail++; $display("FAIL step_upd e%0d: got %b expected %b", e, upd[0], e == 3);
            end
            n_checks++;
            if (wq[1] !== ((e >= 4) ? 5'd1 : 5'd0)) begin
                n_fail++; $display("FAIL depth_wq e%0d: got %b expected %b", e, wq[1], (e >= 4) ? 5'd1 : 5'd0);
            end
            n_checks++;
            if (upd[1] !== (e == 5)) begin
                n_fail++; $display("FAIL depth_upd e%0d: got %b expected %b", e, upd[1], e == 5);
            end
            if (e == 3) begin
                n_checks++;
                if (wqb[0] !== 5'd1) begin
                    n_fail++; $display("FAIL step_bin e3: got %0d expected 1", wqb[0]);
                end
            end
            if (e == 4) begin
                n_checks++;
                if (wf[0] !== 5'd2) begin
                    n_fail++; $display("FAIL step_wfill e4: got %0d expected 2", wf[0]);
                end
            end
            if (e == 6) begin
                n_checks++;
                if (wf[1] !== 5'd2) begin
                    n_fail++; $display("FAIL depth_wfill e6: got %0d expected 2", wf[1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        tick(1'b1, 5'd0, 5'd1, 1'b0);
        repeat (7) tick(1'b0, 5'b10000, 5'd1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (wqb[d] !== 5'd31 || wf[d] !== 5'd2) begin
                n_fail++; $display("FAIL wrap_31[%0d]: got bin=%0d wfill=%0d expected bin=31 wfill=2", d, wqb[d], wf[d]);
            end
        end
        repeat (7) tick(1'b0, 5'b00000, 5'd1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (wqb[d] !== 5'd0 || wf[d] !== 5'd1) begin
                n_fail++; $display("FAIL wrap_0[%0d]: got bin=%0d wfill=%0d expected bin=0 wfill=1", d, wqb[d], wf[d]);
            end
        end
    endtask

    task automatic test_gray_err();
        tick(1'b1, 5'd0, 5'd0, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            tick(1'b0, 5'b00011, 5'd0, 1'b0);
            n_checks++;
            if (gerr[0] !== (e >= 3)) begin
                n_fail++; $display("FAIL gerr_set e%0d: got %b expected %b", e, gerr[0], e >= 3);
            end
        end
        tick(1'b0, 5'b00011, 5'd0, 1'b1);
        n_checks++;
        if (gerr[0] !== 1'b0) begin
            n_fail++; $display("FAIL gerr_clear: got %b expected 0", gerr[0]);
        end
        tick(1'b0, 5'b01100, 5'd0, 1'b0);
        tick(1'b0, 5'b01100, 5'd0, 1'b0);
        tick(1'b0, 5'b01100, 5'd0, 1'b1);
        n_checks++;
        if (gerr[0] !== 1'b1) begin
            n_fail++; $display("FAIL gerr_set_wins: got %b expected 1", gerr[0]);
        end
        tick(1'b0, 5'b01100, 5'd0, 1'b0);
        n_checks++;
        if (gerr[0] !== 1'b1) begin
            n_fail++; $display("FAIL gerr_sticky: got %b expected 1", gerr[0]);
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 5'd0, 5'd0, 1'b0);
        repeat (6) tick(1'b0, 5'b00011, 5'd0, 1'b0);
        repeat (6) tick(1'b0, 5'b00100, 5'd0, 1'b0);
        n_checks++;
        if (wqb[0] !== 5'd7 || gerr[0] !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got bin=%0d err=%b expected bin=7 err=1", wqb[0], gerr[0]);
        end
        tick(1'b1, 5'b00100, 5'd0, 1'b0);
        n_checks++;
        if ({wq[0], wqb[0], wf[0], upd[0], gerr[0]} !== 17'd0) begin
            n_fail++; $display("FAIL midrst_zero: got wq=%b bin=%0d wf=%0d upd=%b err=%b expected all 0",
                               wq[0], wqb[0], wf[0], upd[0], gerr[0]);
        end
        for (int e = 1; e <= 3; e++) begin
            tick(1'b0, 5'b00100, 5'd0, 1'b0);
            n_checks++;
            if (upd[0] !== (e == 3)) begin
                n_fail++; $display("FAIL midrst_upd e%0d: got %b expected %b", e, upd[0], e == 3);
            end
        end
        n_checks++;
        if (wqb[0] !== 5'd7) begin
            n_fail++; $display("FAIL midrst_bin: got %0d expected 7", wqb[0]);
        end
    endtask

    task automatic test_walk();
        tick(1'b1, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            repeat (3) begin
                tick(1'b0, b2g(5'(i)), 5'($urandom), 1'b0);
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (wqb[d] !== exp_wqb[d] || wf[d] !== exp_wf[d] || gerr[d] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL walk[%0d] i=%0d: got bin=%0d wf=%0d err=%b expected bin=%0d wf=%0d err=0",
                                 d, i, wqb[d], wf[d], gerr[d], exp_wqb[d], exp_wf[d]);
                    end
                end
            end
        end
    endtask

    // Random single-step walk with occasional jumps, clears and resets.
    task automatic test_random();
        logic [4:0] b;
        logic       rst_v;
        b = '0;
        tick(1'b1, 5'd0, 5'd0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       b = 5'($urandom);
                1, 2:    b = b;
                default: b = b + 5'd1;
            endcase
            rst_v = ($urandom_range(0, 59) == 0);
            tick(rst_v, b2g(b), 5'($urandom), ($urandom_range(0, 7) == 0));
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (wq[d] !== exp_wq[d] || wqb[d] !== exp_wqb[d] || wf[d] !== exp_wf[d] ||
                    upd[d] !== exp_upd[d] || gerr[d] !== exp_gerr[d]) begin
                    n_fail++;
                    $display("FAIL random[%0d] n=%0d: got wq=%b bin=%0d wf=%0d upd=%b err=%b expected wq=%b bin=%0d wf=%0d upd=%b err=%b",
                             d, n, wq[d], wqb[d], wf[d], upd[d], gerr[d],
                             exp_wq[d], exp_wqb[d], exp_wf[d], exp_upd[d], exp_gerr[d]);
                end
            end
        end
    endtask

    initial begin
        wrst_n  = 1'b0;
        rptr    = '0;
        wbin    = '0;
        err_clr = 1'b0;
        test_reset();
        test_step_and_depth();
        test_wrap();
        test_gray_err();
        test_mid_reset();
        test_walk();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
